// File: rtl/stdpipe_pkg.sv
// Shared types and constants for the pipeline-stage register.
package stdpipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam int CNT_W = 2;

endpackage

// File: rtl/stdreg.sv
// Plain write-enabled storage register with asynchronous active-low reset.
module stdreg #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  // Capture the input only when enabled; otherwise hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data <= RESET_VAL;
    end else if (i_wen) begin
      o_data <= i_data;
    end
  end

endmodule

// File: rtl/stdpipereg.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and
// an optional 2-entry skid buffer that makes o_ready a pure state decode.
//
//   state | meaning
//   EMPTY | nothing held, o_valid=0
//   BUSY  | main holds the head entry
//   FULL  | main holds the head, skid holds the next entry (SKID=1 only)
module stdpipereg
  import stdpipe_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SKID      = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_cnt
);

  pipe_state_e      state_q;
  pipe_state_e      state_nxt;
  logic             in_fire;
  logic             out_fire;
  logic             main_wen;
  logic             skid_wen;
  logic             main_from_skid;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  assign o_valid  = (state_q != EMPTY);
  // In skid mode ready depends only on the state register, breaking the
  // combinational back-pressure chain; without skid it passes through.
  assign o_ready  = SKID ? (state_q != FULL) : (!o_valid || i_ready);
  assign in_fire  = i_valid && o_ready;
  assign out_fire = o_valid && i_ready;

  assign o_cnt = (state_q == FULL) ? CNT_W'(2) :
                 (state_q == BUSY) ? CNT_W'(1) : CNT_W'(0);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and data write-enable decode; flush overrides everything.
  always_comb begin
    state_nxt      = state_q;
    main_wen       = 1'b0;
    skid_wen       = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_nxt = BUSY;
          main_wen  = 1'b1;
        end
      end
      BUSY: begin
        if (in_fire && !out_fire && SKID) begin
          state_nxt = FULL;
          skid_wen  = 1'b1;
        end else if (in_fire) begin
          main_wen  = 1'b1;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (!SKID) begin
          state_nxt = EMPTY;
        end else if (out_fire) begin
          state_nxt      = BUSY;
          main_wen       = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (i_flush) begin
      state_nxt = EMPTY;
      main_wen  = 1'b0;
      skid_wen  = 1'b0;
    end
  end

  assign main_d = main_from_skid ? skid_q : i_data;

  stdreg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wen   (main_wen),
    .i_data  (main_d),
    .o_data  (o_data)
  );

  if (SKID) begin : g_skid
    stdreg #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_skid (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_wen   (skid_wen),
      .i_data  (i_data),
      .o_data  (skid_q)
    );
  end else begin : g_no_skid
    assign skid_q = RESET_VAL;
  end

endmodule

// File: tb/tb_stdpipereg.sv
// Directed bench for stdpipereg: one skid-mode and one pass-through instance.
module tb_stdpipereg;

  localparam int               W  = 16;
  localparam logic [W-1:0]     RV = 16'hA5A5;

  logic         clk = 1'b0;
  logic         rst_n;

  logic         f1, v1, r1;
  logic [W-1:0] d1;
  logic         ov1, or1;
  logic [W-1:0] od1;
  logic [1:0]   c1;

  logic         f0, v0, r0;
  logic [W-1:0] d0;
  logic         ov0, or0;
  logic [W-1:0] od0;
  logic [1:0]   c0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  stdpipereg #(.WIDTH(W), .RESET_VAL(RV), .SKID(1'b1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(f1), .i_valid(v1), .o_ready(or1),
    .i_data(d1), .o_valid(ov1), .i_ready(r1), .o_data(od1), .o_cnt(c1)
  );

  stdpipereg #(.WIDTH(W), .RESET_VAL(RV), .SKID(1'b0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(f0), .i_valid(v0), .o_ready(or0),
    .i_data(d0), .o_valid(ov0), .i_ready(r0), .o_data(od0), .o_cnt(c0)
  );

  // Packed status {o_valid, o_ready, o_cnt, o_data} of each instance.
  function automatic logic [19:0] st1();
    return {ov1, or1, c1, od1};
  endfunction
  function automatic logic [19:0] st0();
    return {ov0, or0, c0, od0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    f1 = 0; v1 = 0; r1 = 0; d1 = '0;
    f0 = 0; v0 = 0; r0 = 0; d0 = '0;
    #12;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      nvec++;
      if (st1() !== {1'b0, 1'b1, 2'd0, RV}) begin
        nerr++;
        $display("FAIL reset_idle_skid cyc%0d: got %h expected %h", i, st1(), {1'b0, 1'b1, 2'd0, RV});
      end
      nvec++;
      if (st0() !== {1'b0, 1'b1, 2'd0, RV}) begin
        nerr++;
        $display("FAIL reset_idle_pass cyc%0d: got %h expected %h", i, st0(), {1'b0, 1'b1, 2'd0, RV});
      end
      step();
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] vals [3];
    vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033;
    r1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v1 = 1'b1; d1 = vals[i];
      step();
      nvec++;
      if (st1() !== {1'b1, 1'b1, 2'd1, vals[i]}) begin
        nerr++;
        $display("FAIL stream_%0d: got %h expected %h", i, st1(), {1'b1, 1'b1, 2'd1, vals[i]});
      end
    end
    v1 = 1'b0;
    step();
    nvec++;
    if ({ov1, or1, c1} !== {1'b0, 1'b1, 2'd0}) begin
      nerr++;
      $display("FAIL stream_drain: got %b expected %b", {ov1, or1, c1}, 4'b0100);
    end
  endtask

  task automatic test_back_pressure();
    r1 = 1'b0; v1 = 1'b1; d1 = 16'h000A;
    step();
    nvec++;
    if (st1() !== {1'b1, 1'b1, 2'd1, 16'h000A}) begin
      nerr++;
      $display("FAIL bp_first: got %h expected %h", st1(), {1'b1, 1'b1, 2'd1, 16'h000A});
    end
    d1 = 16'h000B;
    step();
    nvec++;
    if (st1() !== {1'b1, 1'b0, 2'd2, 16'h000A}) begin
      nerr++;
      $display("FAIL bp_full: got %h expected %h", st1(), {1'b1, 1'b0, 2'd2, 16'h000A});
    end
    v1 = 1'b0; d1 = 16'h00EE;
    step();
    nvec++;
    if (st1() !== {1'b1, 1'b0, 2'd2, 16'h000A}) begin
      nerr++;
      $display("FAIL bp_hold: got %h expected %h", st1(), {1'b1, 1'b0, 2'd2, 16'h000A});
    end
    r1 = 1'b1;
    step();
    nvec++;
    if (st1() !== {1'b1, 1'b1, 2'd1, 16'h000B}) begin
      nerr++;
      $display("FAIL bp_drain1: got %h expected %h", st1(), {1'b1, 1'b1, 2'd1, 16'h000B});
    end
    step();
    nvec++;
    if ({ov1, or1, c1} !== {1'b0, 1'b1, 2'd0}) begin
      nerr++;
      $display("FAIL bp_drain2: got %b expected %b", {ov1, or1, c1}, 4'b0100);
    end
  endtask

  task automatic test_pass_through();
    v0 = 1'b1; d0 = 16'h0005; r0 = 1'b0;
    step();
    nvec++;
    if (st0() !== {1'b1, 1'b0, 2'd1, 16'h0005}) begin
      nerr++;
      $display("FAIL pass_stall: got %h expected %h", st0(), {1'b1, 1'b0, 2'd1, 16'h0005});
    end
    r0 = 1'b1; d0 = 16'h0006;
    #1;
    nvec++;
    if (or0 !== 1'b1) begin
      nerr++;
      $display("FAIL pass_ready_comb: got %b expected 1", or0);
    end
    step();
    nvec++;
    if (st0() !== {1'b1, 1'b1, 2'd1, 16'h0006}) begin
      nerr++;
      $display("FAIL pass_refill: got %h expected %h", st0(), {1'b1, 1'b1, 2'd1, 16'h0006});
    end
    v0 = 1'b0;
    step();
    nvec++;
    if ({ov0, or0, c0, od0} !== {1'b0, 1'b1, 2'd0, 16'h0006}) begin
      nerr++;
      $display("FAIL pass_drain: got %h expected %h", st0(), {1'b0, 1'b1, 2'd0, 16'h0006});
    end
    r0 = 1'b0;
  endtask

  task automatic test_flush();
    r1 = 1'b0; v1 = 1'b1; d1 = 16'h0044;
    step();
    d1 = 16'h0055;
    step();
    nvec++;
    if (st1() !== {1'b1, 1'b0, 2'd2, 16'h0044}) begin
      nerr++;
      $display("FAIL flush_setup: got %h expected %h", st1(), {1'b1, 1'b0, 2'd2, 16'h0044});
    end
    f1 = 1'b1; v1 = 1'b1; r1 = 1'b1; d1 = 16'h0066;
    step();
    nvec++;
    if (st1() !== {1'b0, 1'b1, 2'd0, 16'h0044}) begin
      nerr++;
      $display("FAIL flush_prio: got %h expected %h", st1(), {1'b0, 1'b1, 2'd0, 16'h0044});
    end
    f1 = 1'b0; v1 = 1'b0;
    step();
    nvec++;
    if (st1() !== {1'b0, 1'b1, 2'd0, 16'h0044}) begin
      nerr++;
      $display("FAIL flush_after: got %h expected %h", st1(), {1'b0, 1'b1, 2'd0, 16'h0044});
    end
  endtask

  task automatic test_async_reset();
    r1 = 1'b0; v1 = 1'b1; d1 = 16'h0077;
    v0 = 1'b1; d0 = 16'h005A; r0 = 1'b0;
    step();
    v0 = 1'b0; d1 = 16'h0088;
    step();
    v1 = 1'b0;
    nvec++;
    if (st1() !== {1'b1, 1'b0, 2'd2, 16'h0077}) begin
      nerr++;
      $display("FAIL arst_setup: got %h expected %h", st1(), {1'b1, 1'b0, 2'd2, 16'h0077});
    end
    nvec++;
    if (st0() !== {1'b1, 1'b0, 2'd1, 16'h005A}) begin
      nerr++;
      $display("FAIL arst_setup_pass: got %h expected %h", st0(), {1'b1, 1'b0, 2'd1, 16'h005A});
    end
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if (st1() !== {1'b0, 1'b1, 2'd0, RV}) begin
      nerr++;
      $display("FAIL arst_now_skid: got %h expected %h", st1(), {1'b0, 1'b1, 2'd0, RV});
    end
    nvec++;
    if (st0() !== {1'b0, 1'b1, 2'd0, RV}) begin
      nerr++;
      $display("FAIL arst_now_pass: got %h expected %h", st0(), {1'b0, 1'b1, 2'd0, RV});
    end
    #2;
    rst_n = 1'b1;
    r1 = 1'b1;
    step();
    nvec++;
    if (st1() !== {1'b0, 1'b1, 2'd0, RV}) begin
      nerr++;
      $display("FAIL arst_release: got %h expected %h", st1(), {1'b0, 1'b1, 2'd0, RV});
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_pass_through();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/stdpipereg.md
Name: stdpipereg

Overview:
Parametrised pipeline-stage register with a valid/ready handshake, synchronous flush and an optional 2-entry skid buffer. It is the generalised successor to the plain write-enabled stdreg, which it uses for storage. It sits between CPU pipeline stages (IF/ID/EX/LS/WB) and decouples back-pressure so that ready is not a long combinational chain. In SKID mode it sustains one transfer per cycle with a registered upstream ready.

Parameters:
WIDTH, 64, payload width in bits (>=1)
RESET_VAL, 0, reset value of the data registers (main and skid)
SKID, 1, 1 = 2-entry skid buffer with registered o_ready; 0 = single register with combinational ready pass-through

Ports:
i_clk  input  1  clock; all state changes on its rising edge
i_rst_n  input  1  asynchronous active-low reset
i_flush  input  1  synchronous flush; discards all held entries
i_valid  input  1  upstream payload valid
o_ready  output  1  stage can accept; input fires when i_valid && o_ready
i_data  input  WIDTH  upstream payload
o_valid  output  1  downstream payload valid
i_ready  input  1  downstream accepts; output fires when o_valid && i_ready
o_data  output  WIDTH  downstream payload, always the main register
o_cnt  output  2  occupancy: 0, 1 or 2 (2 only when SKID=1)

Behaviour:
- Reset (i_rst_n=0, asynchronous): state=EMPTY, main=skid=RESET_VAL, o_valid=0, o_cnt=0. o_ready=1 in both modes.
- SKID=1 state machine: EMPTY (cnt 0), BUSY (cnt 1, main valid), FULL (cnt 2, main+skid valid).
- SKID=1 outputs: o_valid = (state!=EMPTY); o_ready = (state!=FULL). o_ready decodes only from the state register and never depends on i_ready or i_valid.
- SKID=1 transitions (in = input fire, out = output fire):
  - EMPTY: in -> BUSY, main<=i_data.
  - BUSY: in&&out -> BUSY, main<=i_data. in only -> FULL, skid<=i_data. out only -> EMPTY. Neither -> hold.
  - FULL: out -> BUSY, main<=skid. No out -> hold. in is impossible because o_ready=0.
- SKID=0 behaviour:
  - o_ready = !o_valid || i_ready (combinational).
  - On in, main<=i_data and o_valid<=1.
  - On out without in, o_valid<=0.
  - States are EMPTY and BUSY only.
- Latency: 1 cycle from input fire to o_valid in both modes. Throughput: 1 transfer per cycle under continuous i_ready in both modes.
- Ordering: strict FIFO. The skid entry is never presented before main.
- Flush:
  - i_flush=1 forces state EMPTY at the next edge, overriding any simultaneous in or out.
  - A same-cycle input is dropped even though o_ready was high. Upstream is required to flush coherently.
  - Data registers are not cleared; only valid and state are cleared.
- Data register write enables:
  - main: written only on the cases listed above.
  - skid: written only on BUSY && in && !out && !i_flush.
  - Data does not change while the stage holds.
- o_data is stable while o_valid && !i_ready (AXI-style stability). o_valid never drops without an out or a flush.
- Illegal state encoding (SKID=1): return to EMPTY.
- Reset asserted mid-transfer: immediate EMPTY; held payloads are lost.

Decomposition:
- Package stdpipe_pkg: typedef enum logic [1:0] pipe_state_e {EMPTY=2'd0, BUSY=2'd1, FULL=2'd2}; localparam CNT_W=2.
- Main and skid data registers are instances of stdreg with WIDTH/RESET_VAL passed through and i_wen driven by the write-enable decode above.
- The skid instance is generated only when SKID=1.
- The state/control FSM stays in stdpipereg; no further sub-modules.

Test Plan:
- Reset then idle: after reset release o_valid=0, o_ready=1, o_cnt=0, o_data=RESET_VAL; hold 5 cycles -> unchanged.
- Streaming, SKID=1, i_ready=1: send 0x11,0x22,0x33 on consecutive cycles -> o_data 0x11,0x22,0x33 one cycle later each; o_cnt stays 1; o_ready stays 1.
- Back-pressure, SKID=1: i_ready=0, send 0xA then 0xB -> o_cnt 1 then 2, o_ready=0 after 0xB, o_data=0xA held; raise i_ready -> 0xA then 0xB delivered in order, o_ready returns 1 after the first out.
- SKID=0 pass-through: o_valid=1 with 0x5, i_ready=0 -> o_ready=0; i_ready=1 with i_valid=1 and 0x6 in the same cycle -> o_ready=1 combinationally, next o_data=0x6.
- Flush priority: FULL state, assert i_flush together with i_valid=1 and i_ready=1 -> next cycle o_valid=0, o_cnt=0, o_ready=1, no data delivered.
- Async reset mid-operation: FULL state, pulse i_rst_n low between clock edges -> o_valid=0 and o_cnt=0 immediately without a clock edge; data registers = RESET_VAL.
